pitch_ctrl: RTL and testbench

PITCH_CTRL -- requirements
Module: pitch_ctrl

---
 rtl/pitch_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_pitch_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pitch_ctrl.sv
// pitch_ctrl: turns debounced umpire buttons into ball/strike/out counter pulses and clears.
// Optional pitch statistic counter is built only when PITCH_CTRL_STAT_EN is defined.
module pitch_ctrl (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iBALL_BTN,
  input  logic       iSTRIKE_BTN,
  input  logic       iFOUL_BTN,
  input  logic       iHIT_BTN,
  input  logic       iOUT_BTN,
  input  logic [2:0] iBALL_CNT,
  input  logic [1:0] iSTRIKE_CNT,
  input  logic [1:0] iOUT_CNT,
  output logic       oBALL,
  output logic       oSTRIKE,
  output logic       oOUT,
  output logic       oBS_CLRn,
  output logic       oOUT_CLRn,
  output logic       oWALK,
  output logic       oSIDE_RETIRE,
  output logic       oBUSY,
  output logic [7:0] oPITCH_CNT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECIDE,
    S_ACT,
    S_CLR,
    S_SETTLE
  } state_e;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_HIT,
    EV_OUT,
    EV_BALL,
    EV_STRIKE,
    EV_FOUL
  } event_e;

  typedef struct packed {
    logic ball;
    logic strike;
    logic out;
    logic walk;
    logic retire;
    logic clr_bs;
    logic clr_out;
  } action_t;

  state_e     state_q, state_d;
  event_e     event_q, event_d;
  event_e     new_ev_w;
  action_t    act_q, act_d, act_w;
  logic [4:0] btn_w, btn_prev_q, rise_w;
  logic [1:0] ball_cnt_w, strike_cnt_w, out_cnt_w;
  logic       out_act_w;

  // Bit order doubles as priority order: HIT, OUT, BALL, STRIKE, FOUL.
  assign btn_w  = {iHIT_BTN, iOUT_BTN, iBALL_BTN, iSTRIKE_BTN, iFOUL_BTN};
  assign rise_w = btn_w & ~btn_prev_q;

  // NOTE: sequential state is written with <= so every register samples pre-edge values.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      btn_prev_q <= '0;
    end else begin
      btn_prev_q <= btn_w;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    new_ev_w = EV_NONE;
    if      (rise_w[4]) new_ev_w = EV_HIT;
    else if (rise_w[3]) new_ev_w = EV_OUT;
    else if (rise_w[2]) new_ev_w = EV_BALL;
    else if (rise_w[1]) new_ev_w = EV_STRIKE;
    else if (rise_w[0]) new_ev_w = EV_FOUL;
  end

  // Thermometer codes decode from the top bit down so illegal codes read as the larger count.
  always_comb begin
    ball_cnt_w = 2'd0;
    if      (iBALL_CNT[2]) ball_cnt_w = 2'd3;
    else if (iBALL_CNT[1]) ball_cnt_w = 2'd2;
    else if (iBALL_CNT[0]) ball_cnt_w = 2'd1;

    strike_cnt_w = 2'd0;
    if      (iSTRIKE_CNT[1]) strike_cnt_w = 2'd2;
    else if (iSTRIKE_CNT[0]) strike_cnt_w = 2'd1;

    out_cnt_w = 2'd0;
    if      (iOUT_CNT[1]) out_cnt_w = 2'd2;
    else if (iOUT_CNT[0]) out_cnt_w = 2'd1;
  end

  always_comb begin
    act_w     = '0;
    out_act_w = 1'b0;
    case (event_q)
      EV_BALL: begin
        if (ball_cnt_w == 2'd3) begin
          act_w.walk   = 1'b1;
          act_w.clr_bs = 1'b1;
        end else begin
          act_w.ball = 1'b1;
        end
      end
      EV_STRIKE: begin
        if (strike_cnt_w == 2'd2) out_act_w = 1'b1;
        else                      act_w.strike = 1'b1;
      end
      EV_FOUL: begin
        if (strike_cnt_w != 2'd2) act_w.strike = 1'b1;
      end
      EV_HIT:  act_w.clr_bs = 1'b1;
      EV_OUT:  out_act_w = 1'b1;
      default: ;
    endcase

    // The third out retires the side instead of counting, and resets the out counter.
    if (out_act_w) begin
      act_w.clr_bs = 1'b1;
      if (out_cnt_w == 2'd2) begin
        act_w.retire  = 1'b1;
        act_w.clr_out = 1'b1;
      end else begin
        act_w.out = 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q <= S_IDLE;
      event_q <= EV_NONE;
      act_q   <= '0;
    end else begin
      state_q <= state_d;
      event_q <= event_d;
      act_q   <= act_d;
    end
  end

  always_comb begin
    state_d = state_q;
    event_d = event_q;
    act_d   = act_q;
    case (state_q)
      S_IDLE: begin
        if (new_ev_w != EV_NONE) begin
          event_d = new_ev_w;
          state_d = S_DECIDE;
        end
      end
      S_DECIDE: begin
        act_d   = act_w;
        state_d = S_ACT;
      end
      S_ACT:    state_d = (act_q.clr_bs || act_q.clr_out) ? S_CLR : S_SETTLE;
      S_CLR:    state_d = S_SETTLE;
      S_SETTLE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs decode only registered state, so buttons never reach them combinationally.
  assign oBALL        = (state_q == S_ACT) && act_q.ball;
  assign oSTRIKE      = (state_q == S_ACT) && act_q.strike;
  assign oOUT         = (state_q == S_ACT) && act_q.out;
  assign oWALK        = (state_q == S_ACT) && act_q.walk;
  assign oSIDE_RETIRE = (state_q == S_ACT) && act_q.retire;
  assign oBS_CLRn     = !((state_q == S_CLR) && act_q.clr_bs);
  assign oOUT_CLRn    = !((state_q == S_CLR) && act_q.clr_out);
  assign oBUSY        = (state_q != S_IDLE);

`ifdef PITCH_CTRL_STAT_EN
  logic [7:0] pcnt_q, pcnt_d;
  logic       pitch_ev_w;

  // OUT button events are not pitches; everything else is.
  assign pitch_ev_w = (event_q == EV_BALL) || (event_q == EV_STRIKE) ||
                      (event_q == EV_FOUL) || (event_q == EV_HIT);

  always_comb begin
    pcnt_d = pcnt_q;
    if ((state_q == S_ACT) && pitch_ev_w && (pcnt_q != 8'hFF)) begin
      pcnt_d = pcnt_q + 8'd1;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

  assign oPITCH_CNT = pcnt_q;
`else
  assign oPITCH_CNT = 8'd0;
`endif

endmodule

// File: tb/tb_pitch_ctrl.sv
// tb_pitch_ctrl: event-schedule model of pitch_ctrl checked every cycle, plus directed scenarios.
// Define PITCH_CTRL_STAT_EN for both files to exercise the pitch statistic.
module tb_pitch_ctrl;

  localparam int RING = 16;
  localparam int EV_HIT = 0, EV_OUT = 1, EV_BALL = 2, EV_STRIKE = 3, EV_FOUL = 4;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b1;
  logic [4:0] btn = '0;  // {HIT, OUT, BALL, STRIKE, FOUL}
  logic [2:0] ball_cnt = '0;
  logic [1:0] strike_cnt = '0;
  logic [1:0] out_cnt = '0;
  logic       oBALL, oSTRIKE, oOUT, oBS_CLRn, oOUT_CLRn, oWALK, oSIDE_RETIRE, oBUSY;
  logic [7:0] oPITCH_CNT;

  pitch_ctrl dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .iBALL_BTN   (btn[2]),
    .iSTRIKE_BTN (btn[1]),
    .iFOUL_BTN   (btn[0]),
    .iHIT_BTN    (btn[4]),
    .iOUT_BTN    (btn[3]),
    .iBALL_CNT   (ball_cnt),
    .iSTRIKE_CNT (strike_cnt),
    .iOUT_CNT    (out_cnt),
    .oBALL       (oBALL),
    .oSTRIKE     (oSTRIKE),
    .oOUT        (oOUT),
    .oBS_CLRn    (oBS_CLRn),
    .oOUT_CLRn   (oOUT_CLRn),
    .oWALK       (oWALK),
    .oSIDE_RETIRE(oSIDE_RETIRE),
    .oBUSY       (oBUSY),
    .oPITCH_CNT  (oPITCH_CNT)
  );

  always #5 iCLK = ~iCLK;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Expected per-cycle outputs: {ball, strike, out, walk, retire, bs_clr, out_clr, busy}.
  logic [7:0] exp_ring [RING];
  int         cyc = 0;
  logic [4:0] m_prev = '0;
  bit         pend = 0;
  int         pend_ev = 0;
  int         busy_last = -10;
  int         m_pcnt = 0;
  bit         inc_pend = 0;
  int         mon_cnt [8];

  function automatic int therm(input logic [2:0] c);
    int v = 0;
    for (int i = 0; i < 3; i++) if (c[i]) v = i + 1;
    return v;
  endfunction

  function automatic int pick(input logic [4:0] e);
    for (int i = 4; i >= 0; i--) if (e[i]) return 4 - i;
    return -1;
  endfunction

  // p = {ball, strike, out, walk, retire}
  task automatic decide(input int ev, input int b, input int s, input int o,
                        output logic [4:0] p, output bit cbs, output bit cout, output bit st);
    bit out_act;
    p = '0; cbs = 0; cout = 0; out_act = 0;
    st = (ev != EV_OUT);
    case (ev)
      EV_BALL:   if (b == 3) begin p = 5'b00010; cbs = 1; end else p = 5'b10000;
      EV_STRIKE: if (s == 2) out_act = 1; else p = 5'b01000;
      EV_FOUL:   if (s < 2) p = 5'b01000;
      EV_HIT:    cbs = 1;
      EV_OUT:    out_act = 1;
      default:   ;
    endcase
    if (out_act) begin
      cbs = 1;
      if (o == 2) begin p = 5'b00001; cout = 1; end else p = 5'b00100;
    end
  endtask

  always @(posedge iCLK) begin
    logic [4:0] rise, p;
    bit cbs, cout, st;
    cyc = cyc + 1;
    if (iRST) begin
      for (int i = 0; i < RING; i++) exp_ring[i] = '0;
      m_prev = '0; pend = 0; busy_last = -10; m_pcnt = 0; inc_pend = 0;
    end else begin
      if (inc_pend) begin
        if (m_pcnt < 255) m_pcnt = m_pcnt + 1;
        inc_pend = 0;
      end
      if (pend) begin
        decide(pend_ev, therm(ball_cnt), therm({1'b0, strike_cnt}), therm({1'b0, out_cnt}),
               p, cbs, cout, st);
        exp_ring[cyc % RING] = exp_ring[cyc % RING] | {p, 3'b001};
        if (cbs || cout) begin
          exp_ring[(cyc + 1) % RING] = exp_ring[(cyc + 1) % RING] | {5'b0, cbs, cout, 1'b1};
          exp_ring[(cyc + 2) % RING] = exp_ring[(cyc + 2) % RING] | 8'h01;
          busy_last = cyc + 2;
        end else begin
          busy_last = cyc + 1;
        end
        inc_pend = st;
        pend = 0;
      end
      rise = btn & ~m_prev;
      m_prev = btn;
      if (rise != 0 && cyc - 1 > busy_last) begin
        pend = 1;
        pend_ev = pick(rise);
        for (int j = 0; j < 3; j++) exp_ring[(cyc + j) % RING] = exp_ring[(cyc + j) % RING] | 8'h01;
        busy_last = cyc + 2;
      end
    end
  end

  function automatic logic [7:0] exp_pcnt();
`ifdef PITCH_CTRL_STAT_EN
    return m_pcnt[7:0];
`else
    return 8'd0;
`endif
  endfunction

  always @(negedge iCLK) begin
    logic [7:0] act_v;
    act_v = {oBALL, oSTRIKE, oOUT, oWALK, oSIDE_RETIRE, ~oBS_CLRn, ~oOUT_CLRn, oBUSY};
    if (iRST) begin
      check("reset_outputs", act_v, 8'h00);
      check("reset_pitch_cnt", oPITCH_CNT, 8'h00);
    end else begin
      check("cycle_outputs", act_v, exp_ring[cyc % RING]);
      check("cycle_pitch_cnt", oPITCH_CNT, exp_pcnt());
    end
    exp_ring[cyc % RING] = '0;
    for (int i = 0; i < 8; i++) mon_cnt[i] = mon_cnt[i] + act_v[7 - i];
  end

  task automatic mon_clear();
    for (int i = 0; i < 8; i++) mon_cnt[i] = 0;
  endtask

  // Nibbles: {ball, strike, out, walk, retire, bs_clr, out_clr, busy_cycles}
  function automatic logic [31:0] mon_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < 8; i++) v[31 - 4 * i -: 4] = mon_cnt[i][3:0];
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge iCLK);
    #2;
  endtask

  task automatic press(input logic [4:0] m);
    btn = m;
    tick(1);
    btn = '0;
  endtask

  task automatic run_case(input string name, input logic [2:0] b, input logic [1:0] s,
                          input logic [1:0] o, input logic [4:0] m, input logic [31:0] exp);
    ball_cnt = b; strike_cnt = s; out_cnt = o;
    mon_clear();
    press(m);
    tick(6);
    check(name, mon_vec(), exp);
  endtask

  initial begin
    tick(2);
    check("reset_literal", {oBUSY, oBS_CLRn, oOUT_CLRn, oBALL}, 4'b0110);
    iRST = 1'b0;
    tick(2);

    run_case("ball_at_1",         3'b001, 2'b00, 2'b00, 5'b00100, 32'h1000_0003);
    run_case("ball_at_2",         3'b011, 2'b00, 2'b00, 5'b00100, 32'h1000_0003);
    run_case("walk_at_3",         3'b111, 2'b00, 2'b00, 5'b00100, 32'h0001_0104);
    run_case("walk_illegal_100",  3'b100, 2'b00, 2'b00, 5'b00100, 32'h0001_0104);
    run_case("strike_at_0",       3'b000, 2'b00, 2'b00, 5'b00010, 32'h0100_0003);
    run_case("strikeout_outs_1",  3'b000, 2'b11, 2'b01, 5'b00010, 32'h0010_0104);
    run_case("strikeout_retire",  3'b000, 2'b11, 2'b11, 5'b00010, 32'h0000_1114);
    run_case("foul_at_2",         3'b000, 2'b11, 2'b00, 5'b00001, 32'h0000_0003);
    run_case("foul_illegal_10",   3'b000, 2'b10, 2'b00, 5'b00001, 32'h0000_0003);
    run_case("foul_at_1",         3'b000, 2'b01, 2'b00, 5'b00001, 32'h0100_0003);
    run_case("out_at_0",          3'b000, 2'b00, 2'b00, 5'b01000, 32'h0010_0104);
    run_case("out_retire",        3'b000, 2'b00, 2'b11, 5'b01000, 32'h0000_1114);
    run_case("hit",               3'b011, 2'b01, 2'b00, 5'b10000, 32'h0000_0104);
    run_case("prio_all_hit_wins", 3'b111, 2'b11, 2'b11, 5'b11111, 32'h0000_0104);
    run_case("prio_out_over_ball",3'b000, 2'b00, 2'b00, 5'b01100, 32'h0010_0104);
    run_case("prio_ball_over_str",3'b000, 2'b00, 2'b00, 5'b00110, 32'h1000_0003);
    run_case("prio_str_over_foul",3'b000, 2'b11, 2'b00, 5'b00011, 32'h0010_0104);

    // Cycle-by-cycle walk through a plain BALL event.
    ball_cnt = 3'b001; strike_cnt = '0; out_cnt = '0;
    press(5'b00100);
    check("t_decide", {oBUSY, oBALL}, 2'b10);
    tick(1);
    check("t_act", {oBALL, oBUSY, oBS_CLRn}, 3'b111);
    tick(1);
    check("t_settle", {oBALL, oBUSY, oBS_CLRn}, 3'b011);
    tick(1);
    check("t_idle", oBUSY, 1'b0);
    tick(2);

    // HIT and BALL rise together, BALL then held: only the HIT path, no retrigger.
    ball_cnt = 3'b000;
    mon_clear();
    btn = 5'b10100;
    tick(1);
    btn = 5'b00100;
    tick(10);
    btn = '0;
    tick(4);
    check("hit_ball_held", mon_vec(), 32'h0000_0104);

    // Edge arriving while busy is dropped.
    mon_clear();
    press(5'b00100);
    btn = 5'b00010;
    tick(1);
    btn = '0;
    tick(6);
    check("busy_discard", mon_vec(), 32'h1000_0003);

    // Reset during ACT of a walk: pulse drops at once, no clear follows.
    ball_cnt = 3'b111;
    mon_clear();
    press(5'b00100);
    tick(1);
    check("walk_before_rst", oWALK, 1'b1);
    iRST = 1'b1;
    #1;
    check("rst_drop", {oWALK, oBUSY, oBS_CLRn}, 3'b001);
    tick(1);
    iRST = 1'b0;
    tick(5);
    check("rst_abandon", mon_vec(), 32'h0000_0001);

    // Button held through reset release counts as an edge.
    ball_cnt = 3'b000;
    btn = 5'b00100;
    iRST = 1'b1;
    tick(2);
    mon_clear();
    iRST = 1'b0;
    tick(1);
    btn = '0;
    tick(6);
    check("held_through_reset", mon_vec(), 32'h1000_0003);

`ifdef PITCH_CTRL_STAT_EN
    iRST = 1'b1;
    tick(1);
    iRST = 1'b0;
    tick(1);
    ball_cnt = 3'b000;
    for (int i = 0; i < 260; i++) begin
      press(5'b00100);
      tick(4);
      if (i == 2) check("pcnt_after_3", oPITCH_CNT, 8'd3);
    end
    check("pcnt_saturate", oPITCH_CNT, 8'd255);
`else
    check("pcnt_disabled", oPITCH_CNT, 8'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
